uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte producers.
- Accepts one byte per request/ack handshake, loads it onto the transmitter's Tx_Data, pulses tx_send, then times out the full serial frame plus a guard gap before serving the next requester.
- Sits between the requester logic and the tx_send/Tx_Data inputs of the UART top. The transmitter has no busy output, so frame timing is owned here.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among N_REQ byte producers.
// It captures one byte per grant, pulses tx_send and then times the serial frame
// plus a guard gap itself, because the transmitter exposes no busy flag.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FRAME_BITS   = 11,
    parameter int unsigned GUARD_CYCLES = 2,
    localparam int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 tx_send,
    output logic [7:0]           Tx_Data,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 tx_done
);

    localparam int unsigned FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
    localparam int unsigned CNT_W        = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned GRD_W        = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_GUARD
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GRD_W-1:0]  grd_q, grd_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [7:0]        data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              send_q, send_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hit;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   cand;
    logic [7:0]        req_byte [N_REQ];

    // Unpack the flat data bus into one byte per requester.
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_byte
        assign req_byte[i] = req_data[8*i +: 8];
    end

    // Round-robin search: first set req bit after the last granted index, with wrap.
    always_comb begin
        hit  = 1'b0;
        win  = last_q;
        cand = last_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % N_REQ);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    // Next-state and registered-output logic for the grant/load/send/wait/guard sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grd_d   = grd_q;
        last_d  = last_q;
        gid_d   = gid_q;
        data_d  = data_q;
        ack_d   = '0;
        send_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_LOAD;
                    gid_d   = win;
                    last_d  = win;
                    data_d  = req_byte[win];
                    ack_d   = N_REQ'(1) << win;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
                send_d  = 1'b1;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
                    grd_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (grd_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    grd_d = grd_q + GRD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        // tx_done marks the final cycle of frame-plus-guard; with no guard that is the last WAIT cycle.
        done_d = ((state_d == ST_GUARD) && (grd_d == GUARD_LAST)) ||
                 ((GUARD_CYCLES == 0) && (state_d == ST_WAIT) && (cnt_d == FRAME_LAST));
    end

    // State and output registers; reset puts requester 0 first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grd_q   <= '0;
            last_q  <= LAST_RST;
            gid_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grd_q   <= grd_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ack      = ack_q;
    assign tx_send  = send_q;
    assign Tx_Data  = data_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: dut_a uses a 2-cycle guard, dut_b uses none.
// Both use 4 clocks/bit and 11 bits, so a frame is 44 cycles.
// The stimulus pushes expected grants into a scoreboard queue.
// A negedge monitor pops and checks each entry when tx_send appears.
module tb_uart_tx_arbiter;

    localparam int LIM = 400;

    typedef struct {
        int         dut;
        int         id;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  ack_a, ack_b;
    logic        send_a, send_b;
    logic [7:0]  txd_a, txd_b;
    logic        busy_a, busy_b;
    logic [1:0]  gid_a, gid_b;
    logic        done_a, done_b;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(11), .GUARD_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .req_data(data_a), .ack(ack_a),
        .tx_send(send_a), .Tx_Data(txd_a), .busy(busy_a), .grant_id(gid_a), .tx_done(done_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(11), .GUARD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_data(data_b), .ack(ack_b),
        .tx_send(send_b), .Tx_Data(txd_b), .busy(busy_b), .grant_id(gid_b), .tx_done(done_b)
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int         cyc = 0;
    int         last_send [2] = '{-1, -1};
    int         ack_cyc   [2] = '{-10, -10};
    int         busy_run  [2] = '{0, 0};
    logic       m_r, m_s, m_b, m_dn;
    logic [3:0] m_a;
    logic [7:0] m_td;
    logic [1:0] m_g;
    exp_t       m_e;
    int         done_ofs, busy_len;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_r  = (d == 0) ? rst_a  : rst_b;
            m_a  = (d == 0) ? ack_a  : ack_b;
            m_s  = (d == 0) ? send_a : send_b;
            m_td = (d == 0) ? txd_a  : txd_b;
            m_b  = (d == 0) ? busy_a : busy_b;
            m_g  = (d == 0) ? gid_a  : gid_b;
            m_dn = (d == 0) ? done_a : done_b;
            done_ofs = (d == 0) ? 46 : 44;
            busy_len = (d == 0) ? 48 : 46;
            if (m_r) begin
                chk("rst_outputs", d, 32'({m_a, m_s, m_td, m_b, m_g, m_dn}), 32'(0));
                last_send[d] = -1;
                ack_cyc[d]   = -10;
                busy_run[d]  = 0;
            end else begin
                if (m_a != 4'd0) begin
                    chk("ack_onehot", d, 32'($onehot(m_a)), 32'(1));
                    if (exp_q.size() == 0 || exp_q[0].dut != d)
                        chk("unexpected_ack", d, 32'(m_a), 32'(0));
                    else
                        chk("ack_id", d, 32'(m_a), 32'(1) << exp_q[0].id);
                    ack_cyc[d] = cyc;
                end
                if (m_s) begin
                    chk("send_ack_excl", d, 32'(m_a), 32'(0));
                    if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                        chk("unexpected_send", d, 32'(1), 32'(0));
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("tx_data", d, 32'(m_td), 32'(m_e.data));
                        chk("grant_id", d, 32'(m_g), 32'(m_e.id));
                        chk("ack_to_send", d, 32'(cyc - ack_cyc[d]), 32'(1));
                        if (m_e.gap != 0 && last_send[d] >= 0)
                            chk("send_gap", d, 32'(cyc - last_send[d]), 32'(m_e.gap));
                    end
                    last_send[d] = cyc;
                end
                if (last_send[d] >= 0 && cyc - last_send[d] == done_ofs)
                    chk("tx_done_time", d, 32'(m_dn), 32'(1));
                else if (m_dn)
                    chk("tx_done_spurious", d, 32'(m_dn), 32'(0));
                if (m_b) begin
                    busy_run[d]++;
                end else if (busy_run[d] != 0) begin
                    chk("busy_len", d, 32'(busy_run[d]), 32'(busy_len));
                    busy_run[d] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int d, input int id, input logic [7:0] data, input int gap);
        exp_t e;
        e.dut = d; e.id = id; e.data = data; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((d == 0) ? ack_a : ack_b) == 4'd0 && n < LIM);
        chk("ack_timeout", d, 32'(n < LIM), 32'(1));
    endtask

    task automatic wait_send(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((d == 0) ? send_a : send_b) == 1'b0 && n < LIM);
        chk("send_timeout", d, 32'(n < LIM), 32'(1));
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (((d == 0) ? busy_a : busy_b) == 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", d, 32'(n < LIM), 32'(1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; req_b = '0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Single request from requester 0.
        data_a[7:0] = 8'hA5;
        push(0, 0, 8'hA5, 0);
        req_a = 4'b0001;
        wait_ack(0, n);
        chk("ack_latency", 0, 32'(n), 32'(1));
        req_a = 4'b0000;
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Reset in the middle of WAIT at counter value 20.
        data_a[7:0] = 8'h99;
        push(0, 0, 8'h99, 0);
        req_a = 4'b0001;
        wait_ack(0, n);
        req_a = 4'b0000;
        wait_send(0);
        repeat (21) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);

        // All four requesters; each drops its request once acknowledged.
        data_a = 32'h4433_2211;
        push(0, 0, 8'h11, 0);
        push(0, 1, 8'h22, 49);
        push(0, 2, 8'h33, 49);
        push(0, 3, 8'h44, 49);
        req_a = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, n);
            req_a = req_a & ~ack_a;
        end
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Fairness: req0 held permanently, req2 joins during the first frame.
        data_a = 32'h00C3_005A;
        push(0, 0, 8'h5A, 0);
        push(0, 2, 8'hC3, 49);
        push(0, 0, 8'h5A, 49);
        push(0, 2, 8'hC3, 49);
        req_a = 4'b0001;
        wait_ack(0, n);
        repeat (5) @(negedge clk);
        req_a[2] = 1'b1;
        for (int i = 0; i < 3; i++) wait_ack(0, n);
        req_a = 4'b0000;
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Request from requester 3, with a one-cycle req1 glitch during WAIT.
        data_a[31:24] = 8'h7E;
        push(0, 3, 8'h7E, 0);
        req_a = 4'b1000;
        wait_ack(0, n);
        chk("ack_latency", 0, 32'(n), 32'(1));
        req_a = 4'b0000;
        wait_send(0);
        repeat (10) @(negedge clk);
        req_a = 4'b0010;
        @(negedge clk);
        req_a = 4'b0000;
        wait_idle(0);
        repeat (60) @(negedge clk);

        // No-guard build: single request from requester 1.
        data_b[15:8] = 8'h3C;
        push(1, 1, 8'h3C, 0);
        req_b = 4'b0010;
        wait_ack(1, n);
        chk("ack_latency", 1, 32'(n), 32'(1));
        req_b = 4'b0000;
        wait_idle(1);
        repeat (3) @(negedge clk);

        // No-guard back-to-back: req0 stays high, byte is resampled at the second grant.
        data_b[7:0] = 8'hE1;
        push(1, 0, 8'hE1, 0);
        push(1, 0, 8'hE2, 47);
        req_b = 4'b0001;
        wait_ack(1, n);
        data_b[7:0] = 8'hE2;
        wait_ack(1, n);
        req_b = 4'b0000;
        wait_idle(1);
        repeat (5) @(negedge clk);

        chk("queue_empty", 0, 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
